// File: rtl/triple.sv
// triple: registered unsigned multiply-by-three, result = (a<<1)+a.
// Define TRIPLE_PIPE_EN to add an input register stage (latency 2 instead of 1).
module triple #(
  parameter int IN_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] a,
  input  logic            in_valid,
  output logic [IN_W+1:0] result,
  output logic            out_valid
);

  localparam int OUT_W = IN_W + 2;

  function automatic logic [OUT_W-1:0] times3(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] ext;
    ext = {2'b00, x};
    return (ext << 1'b1) + ext;
  endfunction

  logic [IN_W-1:0] stage_a_s;
  logic            stage_v_s;

`ifdef TRIPLE_PIPE_EN
  logic [IN_W-1:0] a_r;
  logic            in_valid_r;

  // Input stage: a is captured only with in_valid so an idle operand never reaches the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      in_valid_r <= 1'b0;
    end else begin
      in_valid_r <= in_valid;
      if (in_valid) begin
        a_r <= a;
      end else begin
        a_r <= a_r;
      end
    end
  end

  assign stage_a_s = a_r;
  assign stage_v_s = in_valid_r;
`else
  assign stage_a_s = a;
  assign stage_v_s = in_valid;
`endif

  // Product stage: result updates only on a valid operand, out_valid mirrors the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stage_v_s;
      if (stage_v_s) begin
        result <= times3(stage_a_s);
      end else begin
        result <= result;
      end
    end
  end

endmodule

// File: tb/tb_triple.sv
// tb_triple: directed checks of triple against a queue-based latency model,
// plus an IN_W=8 instance for the wide boundary case.
module tb_triple;

`ifdef TRIPLE_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic       in_valid;
  logic [5:0] result;
  logic       out_valid;
  logic [7:0] a8;
  logic       v8;
  logic [9:0] r8;
  logic       ov8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] a;
  } item_t;
  item_t q[$];
  int    exp_res = 0;
  bit    exp_ov = 1'b0;
  int    obs[$];

  triple #(.IN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid),
    .result(result), .out_valid(out_valid)
  );

  triple #(.IN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .in_valid(v8),
    .result(r8), .out_valid(ov8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: each accepted edge enters a queue; the entry L edges old defines the outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_res = 0;
      exp_ov  = 1'b0;
    end else begin
      item_t it;
      q.push_back('{in_valid, a});
      exp_ov = 1'b0;
      if (q.size() >= L) begin
        it = q.pop_front();
        exp_ov = it.v;
        if (it.v) exp_res = 3 * int'(it.a);
      end
    end
  end

  // Compare every cycle away from the active edge and log each emitted product.
  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(exp_ov));
    chk("result", int'(result), exp_res);
    if (out_valid) obs.push_back(int'(result));
  end

  task automatic step(input logic v, input logic [3:0] x);
    in_valid = v;
    a = x;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd9);
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 3, 9, 15, 30, 30};
    rst_n = 1'b0; in_valid = 1'b1; a = 4'd7; a8 = 8'd0; v8 = 1'b0;

    // Reset held with valid input
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_result", int'(result), 0);
      chk("rst_out_valid", int'(out_valid), 0);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Directed stream, back-to-back
    obs.delete();
    step(1'b1, 4'd0); step(1'b1, 4'd1); step(1'b1, 4'd3);
    step(1'b1, 4'd5); step(1'b1, 4'd10); step(1'b1, 4'd10);
    idle(L + 1);
    chk("seq_count", obs.size(), 6);
    for (int i = 0; i < 6 && i < obs.size(); i++) chk("seq_val", obs[i], exp_seq[i]);

    // Boundary a=15 and IN_W=8 a=255
    obs.delete();
    step(1'b1, 4'd15);
    idle(L + 1);
    chk("max4_count", obs.size(), 1);
    if (obs.size() > 0) chk("max4_val", obs[0], 45);
    a8 = 8'd255; v8 = 1'b1;
    @(posedge clk); #2;
    v8 = 1'b0; a8 = 8'd0;
    repeat (L - 1) @(posedge clk);
    #1;
    chk("max8_val", int'(r8), 765);
    chk("max8_valid", int'(ov8), 1);
    @(posedge clk); #1;
    chk("max8_pulse", int'(ov8), 0);
    chk("max8_hold", int'(r8), 765);

    // Bubbles hold the result
    obs.delete();
    step(1'b1, 4'd4);
    step(1'b0, 4'd9);
    step(1'b0, 4'd9);
    idle(L);
    chk("bubble_count", obs.size(), 1);
    if (obs.size() > 0) chk("bubble_val", obs[0], 12);
    chk("bubble_hold", int'(result), 12);

    // Mid-operation reset drops the in-flight product
    obs.delete();
    in_valid = 1'b1; a = 4'd6;
    if (L == 2) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", int'(result), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(L + 1);
    chk("flushed_count", obs.size(), 0);
    chk("flushed_result", int'(result), 0);
    step(1'b1, 4'd2);
    idle(L + 1);
    chk("after_rst_count", obs.size(), 1);
    if (obs.size() > 0) chk("after_rst_val", obs[0], 6);

    // Exhaustive sweep, one operand per cycle
    obs.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i));
    idle(L + 1);
    chk("sweep_count", obs.size(), 16);
    for (int i = 0; i < 16 && i < obs.size(); i++) chk("sweep_val", obs[i], 3 * i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
